// File: rtl/regfile_pkg.sv
// Shared constants, types and the forwarding-select helper for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_DEPTH_B = 5;
  localparam int unsigned DEF_DEPTH   = 32;
  localparam int unsigned REG_ZERO    = 0;

  localparam int unsigned MAX_WR   = 16;
  localparam int unsigned WR_IDX_W = 4;

  typedef struct packed {
    logic                hit;
    logic [WR_IDX_W-1:0] idx;
  } fwd_sel_t;

  // Ascending scan: the highest-numbered matching write port is the one reported.
  function automatic fwd_sel_t fwd_select(input logic [MAX_WR-1:0] match,
                                          input int unsigned       num_wr);
    fwd_sel_t s;
    s.hit = 1'b0;
    s.idx = '0;
    for (int unsigned j = 0; j < MAX_WR; j++) begin
      if (j < num_wr && match[j]) begin
        s.hit = 1'b1;
        s.idx = WR_IDX_W'(j);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on write-back, set dominates a same-cycle clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH_B  = DEF_DEPTH_B,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_sb_set,
  input  logic [DEPTH_B-1:0] i_sb_wa,
  input  logic [DEPTH-1:0]   i_clr,
  output logic [DEPTH-1:0]   o_busy
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_set;
  logic             w_set_ok;

  assign w_set_ok = i_sb_set && (32'(i_sb_wa) < DEPTH) &&
                    !((ZERO_REG != 0) && (32'(i_sb_wa) == REG_ZERO));

  always_comb begin
    w_set = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      w_set[r] = w_set_ok && (32'(i_sb_wa) == r);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_busy <= '0;
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        if (w_set[r])      r_busy[r] <= 1'b1;
        else if (i_clr[r]) r_busy[r] <= 1'b0;
      end
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with prioritised write-through forwarding and a busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH_B  = DEF_DEPTH_B,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_RD*DEPTH_B-1:0] rf_ra,
  output logic [NUM_RD*WIDTH-1:0]   rf_rd,
  output logic [NUM_RD-1:0]         rf_rbusy,
  input  logic [NUM_WR-1:0]         rf_we,
  input  logic [NUM_WR*DEPTH_B-1:0] rf_wa,
  input  logic [NUM_WR*WIDTH-1:0]   rf_wd,
  input  logic                      sb_set,
  input  logic [DEPTH_B-1:0]        sb_wa,
  input  logic [DEPTH_B-1:0]        debug_reg_ra,
  output logic [WIDTH-1:0]          debug_reg_rd,
  output logic [DEPTH-1:0]          debug_busy
);

  function automatic logic addr_ok(input logic [DEPTH_B-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (32'(a) == REG_ZERO));
  endfunction

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [NUM_WR-1:0] w_eff;
  logic [DEPTH-1:0]  w_clr;
  logic [DEPTH-1:0]  w_busy;

  always_comb begin
    w_eff = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      w_eff[j] = rf_we[j] && addr_ok(rf_wa[j*DEPTH_B +: DEPTH_B]);
    end
  end

  always_comb begin
    w_clr = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (w_eff[j] && (32'(rf_wa[j*DEPTH_B +: DEPTH_B]) == r)) w_clr[r] = 1'b1;
      end
    end
  end

  // Ports are scanned in ascending order so the last non-blocking write (highest port) wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned r = 0; r < DEPTH; r++) r_mem[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (w_eff[j] && (32'(rf_wa[j*DEPTH_B +: DEPTH_B]) == r))
            r_mem[r] <= rf_wd[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH_B  (DEPTH_B),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_sb_set (sb_set),
    .i_sb_wa  (sb_wa),
    .i_clr    (w_clr),
    .o_busy   (w_busy)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [DEPTH_B-1:0] w_ra;
    logic [MAX_WR-1:0]  w_match;
    fwd_sel_t           w_sel;
    logic               w_ok;
    logic [WIDTH-1:0]   w_rd;

    assign w_ra = rf_ra[i*DEPTH_B +: DEPTH_B];

    always_comb begin
      w_match = '0;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        w_match[j] = w_eff[j] && (rf_wa[j*DEPTH_B +: DEPTH_B] == w_ra);
      end
    end

    assign w_sel = fwd_select(w_match, NUM_WR);
    // Gating with rstn keeps forwarding off while the array is held in reset.
    assign w_ok  = rstn && addr_ok(w_ra);
    assign w_rd  = !w_ok     ? '0 :
                   w_sel.hit ? rf_wd[32'(w_sel.idx)*WIDTH +: WIDTH] :
                               r_mem[w_ra];

    assign rf_rd[i*WIDTH +: WIDTH] = w_rd;
    assign rf_rbusy[i]             = w_ok && w_busy[w_ra] && !w_sel.hit;
  end

  assign debug_reg_rd = (32'(debug_reg_ra) < DEPTH) ? r_mem[debug_reg_ra] : '0;
  assign debug_busy   = w_busy;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined CPU. It generalises the single-write/dual-read file to NUM_RD read ports and NUM_WR write ports.
- Every read port has write-through forwarding with a defined write priority.
- A per-register busy scoreboard supports hazard detection: a bit is set when an instruction issues and cleared when its result is written back.
- Sits between the ID stage (reads, issue marking) and the WB stage (writes). A debug port serves the on-board monitor.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH_B, 5, address width.
- DEPTH, 32, number of registers (must be ≤ 2**DEPTH_B).
- NUM_RD, 2, number of read ports.
- NUM_WR, 1, number of write ports.
- ZERO_REG, 1, when 1, register 0 is hardwired to zero: writes are ignored, it is never forwarded and never busy.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- rf_ra  in  NUM_RD*DEPTH_B  packed read addresses; port i uses bits [i*DEPTH_B +: DEPTH_B].
- rf_rd  out  NUM_RD*WIDTH  packed read data.
- rf_rbusy  out  NUM_RD  busy flag of the register addressed by each read port.
- rf_we  in  NUM_WR  write enables.
- rf_wa  in  NUM_WR*DEPTH_B  packed write addresses.
- rf_wd  in  NUM_WR*WIDTH  packed write data.
- sb_set  in  1  mark register sb_wa busy (an instruction has issued).
- sb_wa  in  DEPTH_B  destination register being marked busy.
- debug_reg_ra  in  DEPTH_B  debug read address.
- debug_reg_rd  out  WIDTH  debug read data (no forwarding).
- debug_busy  out  DEPTH  full busy vector.

Behaviour:
- **Reset.** rstn low immediately clears all registers to 0 and all busy bits to 0, asynchronously.
  - While rstn is low, forwarding is disabled, so every rf_rd reads 0, every rf_rbusy reads 0, debug_reg_rd reads 0 and debug_busy reads 0.
  - Registers update again on the first rising edge after rstn goes high.
- **Effective write.** Write port j is effective when rf_we[j] is 1, rf_wa[j] < DEPTH, and not (ZERO_REG=1 and rf_wa[j]=0).
  - Effective writes commit on the rising edge.
- **Write priority.** If several effective writes target the same address in one cycle, the highest-numbered port wins. The others are dropped silently.
- **Reads.**
  - Reads are combinational, with zero latency.
  - rf_rd[i] returns the data of the winning effective write whose address equals rf_ra[i] in the current cycle (forwarding). Otherwise it returns the stored value.
  - Reading address 0 with ZERO_REG=1 always returns 0.
  - Reading an address ≥ DEPTH returns 0.
- **Debug read.** debug_reg_rd returns the stored value only; there is no forwarding.
- **Scoreboard.** One busy bit per register, updated on the rising edge.
  - Set: sb_set=1 and the address is valid. If ZERO_REG=1, address 0 is ignored.
  - Clear: any effective write to the register in that cycle.
  - Set and clear to the same address in the same cycle: set wins and the bit ends at 1 (a new producer has overtaken the write-back).
  - Set to a register that is already busy: the bit stays 1. There is no counting.
- **Busy flag.** rf_rbusy[i] is the busy bit of rf_ra[i] AND NOT (an effective write to rf_ra[i] in the current cycle).
  - This means the forwarded value is usable in the same cycle.
  - The current-cycle sb_set does not affect rf_rbusy; the new busy state is visible from the next cycle.
- **Structure.** There are no other state elements. All outputs are combinational functions of state and inputs.

Decomposition:
- **Package regfile_pkg:**
  - default WIDTH, DEPTH_B and DEPTH constants;
  - a helper function that computes the per-port forwarding match and priority (last-writer-wins loop);
  - the constant REG_ZERO = 0.
- **Sub-module regfile_scoreboard:**
  - holds the DEPTH busy bits with the async reset;
  - inputs: clk, rstn, sb_set/sb_wa and the effective-write vector;
  - outputs the busy vector.
- **Top level:** keeps the data array, the write-priority logic, forwarding and the generate loop over read ports.

Test Plan:
- **Reset mid-run.** Write 0xDEADBEEF to r5 and mark r5 busy, then pull rstn low mid-cycle → debug_reg_rd(r5) becomes 0 immediately and debug_busy = 0. After release, a read of r5 returns 0.
- **Forwarding.** rf_we[0]=1, wa=7, wd=0x12345678, with ra0=7 in the same cycle → rf_rd[0] = 0x12345678 before the edge. Next cycle, with we=0 → still 0x12345678.
- **Write collision.** NUM_WR=2, both ports write r3 (port0 = 0x11, port1 = 0x22) → forwarded value and stored value are both 0x22.
- **Zero register.** ZERO_REG=1: write r0 = 0xFFFFFFFF with sb_set on r0 → rf_rd on r0 is 0, debug_reg_rd(r0) is 0, debug_busy[0] = 0.
- **Scoreboard basic.** sb_set on r9 → rf_rbusy is 1 from the next cycle. A later write to r9 → rf_rbusy is 0 in the write cycle and rf_rd shows the forwarded value; busy bit is 0 after the edge.
- **Scoreboard overtake.** Same cycle: sb_set on r4 and a write to r4 of 0x55 → after the edge, busy[4] = 1 and the stored value is 0x55.
